ball_hit_detector: RTL and testbench
====================================

BALL_HIT_DETECTOR -- requirements
Module: ball_hit_detector

Interface
REQ-001 Parameter EDGE, default 4: thickness in pixels of each side zone inside the 64x64 ball sprite.
REQ-002 Parameter MIN_PIXELS, default 3: per-frame pixel overlap count at which a side registers as hit.
REQ-003 clk  in  1  system pixel clock; the block's only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 startOfFrame  in  1  one-cycle pulse on the first pixel of each frame.
REQ-006 ballDR  in  1  ball drawing request for the current pixel.
REQ-007 ballOffsetX, ballOffsetY  in  11 each  pixel offset inside the ball sprite, 0..63.
REQ-008 objDR  in  4  drawing requests {wall, flipper, bumper, spring} for the current pixel.
REQ-009 hit  out  4  latched per-frame hit sides {Left, Top, Right, Bottom} (bit 3..0).
REQ-010 objHit  out  4  latched per-frame set of object types overlapped by the ball, same bit order as objDR.
REQ-011 hitValid  out  1  one-cycle pulse marking new hit/objHit values.

Function
REQ-012 Overlap pixel: ballDR=1 and objDR!=0 in the same cycle.
REQ-013 Zone classification: Left offsetX<EDGE; Right offsetX>=64-EDGE; Top offsetY<EDGE; Bottom offsetY>=64-EDGE.
REQ-014 A corner pixel belongs to both its zones and increments both counters.
REQ-015 One 4-bit saturating counter per side; +1 per overlap pixel in that zone; holds at 15.
REQ-016 objAcc[3:0] ORs in objDR on every overlap pixel, regardless of zone.
REQ-017 On startOfFrame: hit[i] <= (counter[i] >= MIN_PIXELS), objHit <= objAcc, hitValid <= 1, all registered one cycle later.
REQ-018 hitValid SHALL be 1 for exactly the cycle after startOfFrame, 0 otherwise.
REQ-019 hit and objHit SHALL hold their values between hitValid pulses.
REQ-020 In the startOfFrame cycle, counters/objAcc reload with that pixel's contribution only (0 or 1, objDR or 0); that pixel belongs to the new frame.
REQ-021 Overlap pixels outside all four zones SHALL affect objAcc only.
REQ-022 Offsets >63 with ballDR=1 SHALL be treated as outside all zones.
REQ-023 Two-state FSM: IDLE (after reset, ignores pixels until first startOfFrame) -> ACCUM (counting); ACCUM stays ACCUM on every startOfFrame.
REQ-024 First startOfFrame after reset SHALL produce hitValid with hit=0 and objHit=0.

Reset
REQ-025 reset SHALL force state=IDLE, counters=0, objAcc=0, hit=0, objHit=0, hitValid=0 on the next edge.
REQ-026 reset has priority over startOfFrame and pixel inputs in the same cycle.
REQ-027 Reset mid-frame discards that frame's partial accumulation; no hitValid until next startOfFrame.

Structure
REQ-028 Side index constants (LEFT=3, TOP=2, RIGHT=1, BOTTOM=0), EDGE and MIN_PIXELS defaults go in the shared defines_ball package beside WIDTH/HEIGHT.
REQ-029 Zone bounds derived from defines_ball WIDTH/HEIGHT, never hard-coded 64.
REQ-030 Bit order of hit SHALL match the {Left, Top, Right, Bottom} order used by defines HIT_COLORS.
REQ-031 Sub-module hit_side_counter (4-bit saturating counter with clear/load) instantiated four times.

Verification
REQ-032 3 overlap pixels at offset (0,30), then startOfFrame -> next cycle hit=4'b1000, hitValid=1, objHit per objDR.
REQ-033 2 overlap pixels at (63,10) -> hit=4'b0000 (below MIN_PIXELS=3).
REQ-034 4 overlap pixels at corner (0,0) -> hit=4'b1100.
REQ-035 20 overlap pixels in Bottom zone -> counter saturates at 15, hit=4'b0001; next frame empty -> hit=0.
REQ-036 Overlap pixel coincident with startOfFrame -> excluded from latched frame, counted in following frame.
REQ-037 Reset asserted mid-frame after 5 Left pixels -> all outputs 0; next startOfFrame -> hitValid=1, hit=0.

Source files
------------

// File: rtl/defines_ball.sv
// Shared constants for the ball sprite: geometry, hit-side indices and defaults.
// Hit-side indices mirror the colour order in HIT_COLORS: {Left, Top, Right, Bottom}.
package defines_ball;

  localparam int WIDTH  = 64;
  localparam int HEIGHT = 64;

  localparam int LEFT   = 3;
  localparam int TOP    = 2;
  localparam int RIGHT  = 1;
  localparam int BOTTOM = 0;

  localparam int EDGE_DEFAULT       = 4;
  localparam int MIN_PIXELS_DEFAULT = 3;

  localparam logic [3:0][7:0] HIT_COLORS = {8'hE0, 8'h1C, 8'h03, 8'hFC};

  typedef enum logic {ST_IDLE, ST_ACCUM} hit_state_e;

  // Side zones of one sprite pixel; anything outside the sprite hits no zone.
  function automatic logic [3:0] zone_mask(input logic [10:0] x, input logic [10:0] y,
                                           input int edge_w);
    logic [3:0] m;
    m = '0;
    if (x < 11'(WIDTH) && y < 11'(HEIGHT)) begin
      m[LEFT]   = x <  11'(edge_w);
      m[TOP]    = y <  11'(edge_w);
      m[RIGHT]  = x >= 11'(WIDTH - edge_w);
      m[BOTTOM] = y >= 11'(HEIGHT - edge_w);
    end
    return m;
  endfunction

endpackage

// File: rtl/hit_side_counter.sv
// 4-bit saturating overlap counter for one ball side.
// load_i restarts the count with the current pixel's contribution.
module hit_side_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       inc_i,
  output logic [3:0] cnt_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = {3'b000, inc_i};
    else if (inc_i && cnt_q != 4'hF)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ball_hit_detector.sv
// Per-frame ball collision detector: counts overlap pixels per side zone and
// latches hit sides plus touched object types at each start of frame.
module ball_hit_detector
  import defines_ball::*;
#(
  parameter int EDGE       = EDGE_DEFAULT,
  parameter int MIN_PIXELS = MIN_PIXELS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        ballDR,
  input  logic [10:0] ballOffsetX,
  input  logic [10:0] ballOffsetY,
  input  logic [3:0]  objDR,
  output logic [3:0]  hit,
  output logic [3:0]  objHit,
  output logic        hitValid
);

  hit_state_e      state_q;
  logic [3:0]      hit_q, objHit_q, objAcc_q, objAcc_d;
  logic            hitValid_q;
  logic            overlap, count_en;
  logic [3:0]      zone, side_inc, side_hit;
  logic [3:0][3:0] cnt;

  assign overlap  = ballDR && (objDR != 4'b0000);
  assign zone     = zone_mask(ballOffsetX, ballOffsetY, EDGE);
  // The start-of-frame pixel already belongs to the new frame, even out of IDLE.
  assign count_en = (state_q == ST_ACCUM) || startOfFrame;
  assign side_inc = {4{overlap && count_en}} & zone;

  for (genvar g = 0; g < 4; g++) begin : g_side
    hit_side_counter u_cnt (
      .clk    (clk),
      .reset  (reset),
      .load_i (startOfFrame),
      .inc_i  (side_inc[g]),
      .cnt_o  (cnt[g])
    );
    assign side_hit[g] = 32'(cnt[g]) >= MIN_PIXELS;
  end

  always_comb begin
    objAcc_d = objAcc_q;
    if (startOfFrame)
      objAcc_d = overlap ? objDR : 4'b0000;
    else if (overlap && state_q == ST_ACCUM)
      objAcc_d = objAcc_q | objDR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      objAcc_q   <= '0;
      hit_q      <= '0;
      objHit_q   <= '0;
      hitValid_q <= 1'b0;
    end else begin
      objAcc_q   <= objAcc_d;
      hitValid_q <= 1'b0;
      if (startOfFrame) begin
        state_q    <= ST_ACCUM;
        hitValid_q <= 1'b1;
        // Nothing was accumulated before the first frame boundary.
        hit_q      <= (state_q == ST_ACCUM) ? side_hit : 4'b0000;
        objHit_q   <= (state_q == ST_ACCUM) ? objAcc_q : 4'b0000;
      end
    end
  end

  assign hit      = hit_q;
  assign objHit   = objHit_q;
  assign hitValid = hitValid_q;

endmodule

// File: tb/tb_ball_hit_detector.sv
// Scoreboard bench for ball_hit_detector: a behavioural frame model pushes the
// expected {hit, objHit} at every start of frame; tasks pop and compare.
module tb_ball_hit_detector;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, ballDR;
  logic [10:0] ballOffsetX, ballOffsetY;
  logic [3:0]  objDR, hit, objHit;
  logic        hitValid;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_q[$];
  int         m_cnt[4];
  logic [3:0] m_obj;
  bit         m_active;

  always #5 clk = ~clk;

  ball_hit_detector dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .ballDR(ballDR),
    .ballOffsetX(ballOffsetX), .ballOffsetY(ballOffsetY), .objDR(objDR),
    .hit(hit), .objHit(objHit), .hitValid(hitValid)
  );

  // Zones for a 64x64 sprite with 4-pixel edges, bit order {L,T,R,B}.
  function automatic logic [3:0] mzone(input int x, input int y);
    if (x > 63 || y > 63) return 4'b0000;
    return {x < 4, y < 4, x >= 60, y >= 60};
  endfunction

  function automatic logic [3:0] mhit();
    logic [3:0] h;
    for (int i = 0; i < 4; i++) h[i] = (m_cnt[i] >= 3);
    return h;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_obj    = 4'b0000;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    sb_q.delete();
  endtask

  // One pixel cycle: apply inputs at the falling edge and advance the model.
  task automatic drive(input bit s, input bit b, input int x, input int y, input logic [3:0] o);
    logic [3:0] z;
    bit ov;
    @(negedge clk);
    startOfFrame = s; ballDR = b; objDR = o;
    ballOffsetX = 11'(x); ballOffsetY = 11'(y);
    ov = b && (o != 4'b0000);
    z  = ov ? mzone(x, y) : 4'b0000;
    if (s) begin
      sb_q.push_back(m_active ? {mhit(), m_obj} : 8'h00);
      m_active = 1;
      for (int i = 0; i < 4; i++) m_cnt[i] = z[i] ? 1 : 0;
      m_obj = ov ? o : 4'b0000;
    end else if (m_active) begin
      for (int i = 0; i < 4; i++) if (z[i] && m_cnt[i] < 15) m_cnt[i]++;
      if (ov) m_obj = m_obj | o;
    end
  endtask

  task automatic pixels(input int n, input int x, input int y, input logic [3:0] o);
    for (int i = 0; i < n; i++) drive(0, 1, x, y, o);
  endtask

  // Call right after the start-of-frame cycle was driven.
  task automatic check_frame(input string name, input logic [3:0] exp_hit, input logic [3:0] exp_obj);
    logic [7:0] e;
    drive(0, 0, 0, 0, 4'b0000);
    checks++;
    if (hitValid !== 1'b1) begin
      errors++; $display("FAIL %s hitValid: got %b want 1", name, hitValid);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL %s scoreboard: empty, got hit=%b", name, hit);
    end else begin
      e = sb_q.pop_front();
      if (hit !== e[7:4] || objHit !== e[3:0]) begin
        errors++;
        $display("FAIL %s model: got hit=%b objHit=%b want hit=%b objHit=%b",
                 name, hit, objHit, e[7:4], e[3:0]);
      end
    end
    checks++;
    if (hit !== exp_hit || objHit !== exp_obj) begin
      errors++;
      $display("FAIL %s value: got hit=%b objHit=%b want hit=%b objHit=%b",
               name, hit, objHit, exp_hit, exp_obj);
    end
    drive(0, 0, 0, 0, 4'b0000);
    checks++;
    if (hitValid !== 1'b0 || hit !== exp_hit || objHit !== exp_obj) begin
      errors++;
      $display("FAIL %s hold: got hitValid=%b hit=%b objHit=%b want 0 %b %b",
               name, hitValid, hit, objHit, exp_hit, exp_obj);
    end
  endtask

  task automatic do_reset(input string name, input bit s, input bit b, input int x, input int y,
                          input logic [3:0] o);
    @(negedge clk);
    reset = 1'b1; startOfFrame = s; ballDR = b; objDR = o;
    ballOffsetX = 11'(x); ballOffsetY = 11'(y);
    model_reset();
    @(negedge clk);
    reset = 1'b0; startOfFrame = 1'b0; ballDR = 1'b0; objDR = 4'b0000;
    checks++;
    if (hit !== 4'b0000 || objHit !== 4'b0000 || hitValid !== 1'b0) begin
      errors++;
      $display("FAIL %s: got hit=%b objHit=%b hitValid=%b want all 0", name, hit, objHit, hitValid);
    end
    drive(0, 0, 0, 0, 4'b0000);
    checks++;
    if (hitValid !== 1'b0) begin
      errors++; $display("FAIL %s after: got hitValid=%b want 0", name, hitValid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; startOfFrame = 1'b0; ballDR = 1'b0; objDR = 4'b0000;
    ballOffsetX = '0; ballOffsetY = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset("reset_state", 0, 0, 0, 0, 4'b0000);
    pixels(3, 0, 30, 4'b0100);  // ignored while idle
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("first_frame", 4'b0000, 4'b0000);
  endtask

  task automatic test_sides();
    pixels(3, 0, 30, 4'b0100);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("left3", 4'b1000, 4'b0100);
    pixels(2, 63, 10, 4'b0001);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("right2", 4'b0000, 4'b0001);
    pixels(4, 0, 0, 4'b1000);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("corner", 4'b1100, 4'b1000);
    pixels(3, 1, 30, 4'b1000);
    pixels(3, 30, 1, 4'b1000);
    pixels(3, 61, 30, 4'b1000);
    pixels(3, 30, 61, 4'b1000);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("all_sides", 4'b1111, 4'b1000);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) drive(0, 1, 30, 62, (i % 2) ? 4'b0010 : 4'b0100);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("bottom_sat", 4'b0001, 4'b0110);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("empty_after_sat", 4'b0000, 4'b0000);
  endtask

  task automatic test_outside();
    pixels(4, 30, 30, 4'b1000);
    pixels(4, 100, 0, 4'b0001);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 4'b1111);
    pixels(3, 0, 0, 4'b0000);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("outside", 4'b0000, 4'b1001);
  endtask

  task automatic test_sof_pixel();
    pixels(2, 0, 5, 4'b0100);
    drive(1, 1, 0, 5, 4'b0100);
    check_frame("sof_excluded", 4'b0000, 4'b0100);
    pixels(2, 0, 5, 4'b0001);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("sof_counted", 4'b1000, 4'b0101);
  endtask

  task automatic test_reset_mid();
    pixels(5, 0, 30, 4'b0100);
    do_reset("reset_mid", 0, 0, 0, 0, 4'b0000);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("after_reset", 4'b0000, 4'b0000);
    pixels(3, 0, 30, 4'b0100);
    do_reset("reset_priority", 1, 1, 0, 30, 4'b0100);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("after_prio", 4'b0000, 4'b0000);
    pixels(3, 30, 0, 4'b0010);
    drive(1, 0, 0, 0, 4'b0000);
    check_frame("top_after_reset", 4'b0100, 4'b0010);
  endtask

  initial begin
    test_reset();
    test_sides();
    test_saturate();
    test_outside();
    test_sof_pixel();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
